// File: rtl/mitm_pkg.sv
// rtl/mitm_pkg.sv - shared state codes, opcodes and width helpers for the MITM rule engine
package mitm_pkg;

  typedef logic [2:0] mitm_state_t;

  localparam mitm_state_t ST_IDLE   = 3'd0;
  localparam mitm_state_t ST_SYNC   = 3'd1;
  localparam mitm_state_t ST_CMD    = 3'd2;
  localparam mitm_state_t ST_ADDR   = 3'd3;
  localparam mitm_state_t ST_DATA   = 3'd4;
  localparam mitm_state_t ST_FINISH = 3'd5;

  localparam logic [2:0] OP_READ  = 3'b110;
  localparam logic [2:0] OP_WRITE = 3'b101;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 1; i < v; i = i * 2) r++;
    return r;
  endfunction

  function automatic int idx_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/mitm_rule_table.sv
// rtl/mitm_rule_table.sv - substitution rule storage with lowest-index-wins registered lookup
module mitm_rule_table #(
  parameter int NUM_RULES = 4,
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int IDX_W     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 wr_valid,
  input  logic                 wr_ro,
  input  logic                 lookup_en,
  input  logic [ADDR_BITS-1:0] lookup_addr,
  output logic                 hit,
  output logic [IDX_W-1:0]     hit_idx,
  output logic [DATA_BITS-1:0] hit_data,
  output logic                 hit_ro
);

  logic [ADDR_BITS-1:0] addr_q  [NUM_RULES];
  logic [DATA_BITS-1:0] data_q  [NUM_RULES];
  logic                 valid_q [NUM_RULES];
  logic                 ro_q    [NUM_RULES];

  logic                 m_hit;
  logic [IDX_W-1:0]     m_idx;
  logic [DATA_BITS-1:0] m_data;
  logic                 m_ro;

  // Scan from the top so the lowest matching index is the last to assign.
  always_comb begin
    m_hit  = 1'b0;
    m_idx  = '0;
    m_data = '0;
    m_ro   = 1'b0;
    for (int i = NUM_RULES - 1; i >= 0; i--) begin
      if (valid_q[i] && (addr_q[i] == lookup_addr)) begin
        m_hit  = 1'b1;
        m_idx  = IDX_W'(i);
        m_data = data_q[i];
        m_ro   = ro_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_RULES; i++) begin
        addr_q[i]  <= '0;
        data_q[i]  <= '0;
        valid_q[i] <= 1'b0;
        ro_q[i]    <= 1'b0;
      end
      hit      <= 1'b0;
      hit_idx  <= '0;
      hit_data <= '0;
      hit_ro   <= 1'b0;
    end else begin
      if (wr_en && (int'(wr_idx) < NUM_RULES)) begin
        addr_q[wr_idx]  <= wr_addr;
        data_q[wr_idx]  <= wr_data;
        valid_q[wr_idx] <= wr_valid;
        ro_q[wr_idx]    <= wr_ro;
      end
      if (lookup_en) begin
        hit      <= m_hit;
        hit_idx  <= m_idx;
        hit_data <= m_data;
        hit_ro   <= m_ro;
      end
    end
  end

endmodule

// File: rtl/mitm_rule_engine.sv
// rtl/mitm_rule_engine.sv - bus-word MITM substitution FSM; MITM_HIT_CNT_EN adds a hit_count output
module mitm_rule_engine
  import mitm_pkg::*;
#(
  parameter int MAX_DATA_SIZE = 9,
  parameter int CMD_BITS      = 3,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_RULES     = 4,
  parameter int CONTINUOUS    = 0,
  localparam int RULE_IDX_W   = idx_width(NUM_RULES),
  localparam int SIZE_W       = clog2(MAX_DATA_SIZE + 1)
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic                     mitm_start,
  input  logic                     eval,
  input  logic [MAX_DATA_SIZE-1:0] real_miso_data,
  input  logic [MAX_DATA_SIZE-1:0] real_mosi_data,
  input  logic                     rule_wr_en,
  input  logic [RULE_IDX_W-1:0]    rule_idx,
  input  logic [ADDR_BITS-1:0]     rule_addr,
  input  logic [DATA_BITS-1:0]     rule_data,
  input  logic                     rule_en,
  input  logic                     rule_ro,
  output logic [MAX_DATA_SIZE-1:0] fake_miso_data,
  output logic [MAX_DATA_SIZE-1:0] fake_mosi_data,
  output logic [SIZE_W-1:0]        data_size,
  output logic                     fake_miso_select,
  output logic                     fake_mosi_select,
  output logic                     eval_done,
  output logic                     mitm_done
`ifdef MITM_HIT_CNT_EN
  ,
  output logic [15:0]              hit_count
`endif
);

  mitm_state_t              state_q;
  logic                     busy_q;
  logic [CMD_BITS-1:0]      opcode_q;
  logic [ADDR_BITS-1:0]     addr_q;
  logic [MAX_DATA_SIZE-1:0] pend_miso, pend_mosi;
  logic                     pend_msel, pend_wsel;

  logic                     hit;
  logic [RULE_IDX_W-1:0]    hit_idx_unused;
  logic [DATA_BITS-1:0]     hit_data;
  logic                     hit_ro;

  logic commit, lookup_en, is_read, is_write;

  // Second BUSY cycle: results are registered and eval_done rises.
  assign commit    = !eval_done && busy_q;
  assign lookup_en = commit && (state_q == ST_ADDR);
  assign is_read   = (opcode_q == CMD_BITS'(OP_READ));
  assign is_write  = (opcode_q == CMD_BITS'(OP_WRITE));

  mitm_rule_table #(
    .NUM_RULES (NUM_RULES),
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (DATA_BITS),
    .IDX_W     (RULE_IDX_W)
  ) u_table (
    .clk         (sys_clk),
    .rst         (rst),
    .wr_en       (rule_wr_en),
    .wr_idx      (rule_idx),
    .wr_addr     (rule_addr),
    .wr_data     (rule_data),
    .wr_valid    (rule_en),
    .wr_ro       (rule_ro),
    .lookup_en   (lookup_en),
    .lookup_addr (addr_q),
    .hit         (hit),
    .hit_idx     (hit_idx_unused),
    .hit_data    (hit_data),
    .hit_ro      (hit_ro)
  );

  always_comb begin
    data_size = '0;
    case (state_q)
      ST_CMD:  data_size = SIZE_W'(CMD_BITS);
      ST_ADDR: data_size = SIZE_W'(ADDR_BITS);
      ST_DATA: data_size = SIZE_W'(DATA_BITS);
      default: data_size = '0;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      busy_q           <= 1'b0;
      eval_done        <= 1'b1;
      mitm_done        <= 1'b0;
      opcode_q         <= '0;
      addr_q           <= '0;
      pend_miso        <= '0;
      pend_mosi        <= '0;
      pend_msel        <= 1'b0;
      pend_wsel        <= 1'b0;
      fake_miso_data   <= '0;
      fake_mosi_data   <= '0;
      fake_miso_select <= 1'b0;
      fake_mosi_select <= 1'b0;
    end else begin
      mitm_done <= 1'b0;
      if (!eval_done) begin
        if (!busy_q) begin
          busy_q <= 1'b1;
        end else begin
          busy_q    <= 1'b0;
          eval_done <= 1'b1;
          case (state_q)
            ST_SYNC: state_q <= ST_CMD;
            ST_CMD:  state_q <= ST_ADDR;
            ST_ADDR: state_q <= ST_DATA;
            ST_DATA: begin
              fake_miso_data   <= pend_miso;
              fake_mosi_data   <= pend_mosi;
              fake_miso_select <= pend_msel;
              fake_mosi_select <= pend_wsel;
              if (CONTINUOUS != 0) begin
                state_q <= ST_CMD;
              end else begin
                state_q   <= ST_FINISH;
                mitm_done <= 1'b1;
              end
            end
            default: state_q <= ST_IDLE;
          endcase
        end
      end else begin
        case (state_q)
          ST_IDLE: if (mitm_start) state_q <= ST_SYNC;
          ST_FINISH: begin
            state_q          <= ST_IDLE;
            fake_miso_data   <= '0;
            fake_mosi_data   <= '0;
            fake_miso_select <= 1'b0;
            fake_mosi_select <= 1'b0;
          end
          ST_SYNC, ST_CMD, ST_ADDR, ST_DATA: begin
            if (eval) begin
              eval_done        <= 1'b0;
              busy_q           <= 1'b0;
              fake_miso_data   <= '0;
              fake_mosi_data   <= '0;
              fake_miso_select <= 1'b0;
              fake_mosi_select <= 1'b0;
              pend_miso        <= '0;
              pend_mosi        <= '0;
              pend_msel        <= 1'b0;
              pend_wsel        <= 1'b0;
              if (state_q == ST_CMD) opcode_q <= real_mosi_data[CMD_BITS-1:0];
              if (state_q == ST_ADDR) addr_q <= real_mosi_data[ADDR_BITS-1:0];
              // Write substitution only applies to write-protected rules.
              if (state_q == ST_DATA) begin
                pend_msel <= is_read && hit;
                pend_wsel <= is_write && hit && hit_ro;
                pend_miso <= (is_read && hit) ? MAX_DATA_SIZE'(hit_data) : real_miso_data;
                pend_mosi <= (is_write && hit && hit_ro) ? MAX_DATA_SIZE'(hit_data) : real_mosi_data;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef MITM_HIT_CNT_EN
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      hit_count <= '0;
    end else if (commit && (state_q == ST_DATA) && (pend_msel || pend_wsel) && (hit_count != 16'hFFFF)) begin
      hit_count <= hit_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mitm_rule_engine.sv
// tb/tb_mitm_rule_engine.sv - scoreboard bench for mitm_rule_engine (single-shot and continuous instances)
module tb_mitm_rule_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start0, start1, eval0, eval1;
  logic [8:0] miso, mosi;
  logic       rule_wr_en, rule_en, rule_ro;
  logic [1:0] rule_idx;
  logic [7:0] rule_addr, rule_data;

  logic [8:0] fmiso0, fmosi0, fmiso1, fmosi1;
  logic [3:0] ds0, ds1;
  logic       msel0, wsel0, ed0, done0, msel1, wsel1, ed1, done1;
`ifdef MITM_HIT_CNT_EN
  logic [15:0] hc0, hc1;
`endif

  mitm_rule_engine #(.CONTINUOUS(0)) dut0 (
    .sys_clk(clk), .rst(rst), .mitm_start(start0), .eval(eval0),
    .real_miso_data(miso), .real_mosi_data(mosi),
    .rule_wr_en(rule_wr_en), .rule_idx(rule_idx), .rule_addr(rule_addr),
    .rule_data(rule_data), .rule_en(rule_en), .rule_ro(rule_ro),
    .fake_miso_data(fmiso0), .fake_mosi_data(fmosi0), .data_size(ds0),
    .fake_miso_select(msel0), .fake_mosi_select(wsel0),
    .eval_done(ed0), .mitm_done(done0)
`ifdef MITM_HIT_CNT_EN
    , .hit_count(hc0)
`endif
  );

  mitm_rule_engine #(.CONTINUOUS(1)) dut1 (
    .sys_clk(clk), .rst(rst), .mitm_start(start1), .eval(eval1),
    .real_miso_data(miso), .real_mosi_data(mosi),
    .rule_wr_en(rule_wr_en), .rule_idx(rule_idx), .rule_addr(rule_addr),
    .rule_data(rule_data), .rule_en(rule_en), .rule_ro(rule_ro),
    .fake_miso_data(fmiso1), .fake_mosi_data(fmosi1), .data_size(ds1),
    .fake_miso_select(msel1), .fake_mosi_select(wsel1),
    .eval_done(ed1), .mitm_done(done1)
`ifdef MITM_HIT_CNT_EN
    , .hit_count(hc1)
`endif
  );

  int total = 0;
  int bad = 0;
  int done1_seen = 0;
  logic [20:0] q0[$];
  logic [20:0] q1[$];
  logic [20:0] e0, e1;
  logic prev0 = 1'b1;
  logic prev1 = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [20:0] ex(input logic [8:0] mi, input logic ms,
                                     input logic [8:0] mo, input logic ws, input logic dn);
    return {dn, ws, mo, ms, mi};
  endfunction

  // Monitor: every rising eval_done presents one result to compare.
  always @(negedge clk) begin
    if (ed0 === 1'b1 && prev0 === 1'b0) begin
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_result0 actual=%h required=none", {done0, wsel0, fmosi0, msel0, fmiso0});
      end else begin
        e0 = q0.pop_front();
        chk("result0", 32'({done0, wsel0, fmosi0, msel0, fmiso0}), 32'(e0));
      end
    end
    if (ed1 === 1'b1 && prev1 === 1'b0) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_result1 actual=%h required=none", {done1, wsel1, fmosi1, msel1, fmiso1});
      end else begin
        e1 = q1.pop_front();
        chk("result1", 32'({done1, wsel1, fmosi1, msel1, fmiso1}), 32'(e1));
      end
    end
    if (done1 === 1'b1) done1_seen++;
    prev0 = ed0;
    prev1 = ed1;
  end

  task automatic wait_ready(input bit c);
    for (int i = 0; i < 40 && !(c ? ed1 : ed0); i++) @(negedge clk);
    if (!(c ? ed1 : ed0)) begin
      total++; bad++;
      $display("FAIL eval_done_timeout actual=0 required=1");
    end
  endtask

  task automatic do_eval(input bit c, input logic [8:0] mi, input logic [8:0] mo,
                         input logic [20:0] req, input bit hold2);
    wait_ready(c);
    if (c) q1.push_back(req); else q0.push_back(req);
    miso = mi;
    mosi = mo;
    if (c) eval1 = 1'b1; else eval0 = 1'b1;
    @(negedge clk);
    if (hold2) @(negedge clk);
    eval0 = 1'b0;
    eval1 = 1'b0;
    wait_ready(c);
  endtask

  task automatic wr_rule(input logic [1:0] idx, input logic [7:0] a, input logic [7:0] d,
                         input logic en, input logic ro);
    rule_wr_en = 1'b1; rule_idx = idx; rule_addr = a; rule_data = d; rule_en = en; rule_ro = ro;
    @(negedge clk);
    rule_wr_en = 1'b0;
  endtask

  task automatic start(input bit c);
    if (c) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic txn(input bit c, input bit with_sync, input logic [8:0] op, input logic [8:0] a,
                     input logic [8:0] mi, input logic [8:0] mo, input logic [20:0] req);
    if (with_sync) begin
      start(c);
      do_eval(c, 9'h000, 9'h000, 21'd0, 1'b0);
    end
    do_eval(c, 9'h000, op, 21'd0, 1'b0);
    do_eval(c, 9'h000, a, 21'd0, 1'b0);
    do_eval(c, mi, mo, req, 1'b0);
    if (!c) begin
      @(negedge clk);
      chk("finish_to_idle_done", 32'(done0), 32'd0);
      chk("finish_to_idle_size", 32'(ds0), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; eval0 = 1'b0; eval1 = 1'b0;
    miso = '0; mosi = '0;
    rule_wr_en = 1'b0; rule_idx = '0; rule_addr = '0; rule_data = '0; rule_en = 1'b0; rule_ro = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_eval_done", 32'(ed0), 32'd1);
    chk("rst_data_size", 32'(ds0), 32'd0);
    chk("rst_selects", 32'({msel0, wsel0}), 32'd0);
    chk("rst_fake_data", 32'({fmiso0, fmosi0}), 32'd0);
    chk("rst_mitm_done", 32'(done0), 32'd0);
    chk("rst_eval_done1", 32'(ed1), 32'd1);

    // Read hit on rule0, with data_size tracked through each phase
    wr_rule(2'd0, 8'ha2, 8'hd9, 1'b1, 1'b0);
    start(1'b0);
    chk("size_sync", 32'(ds0), 32'd0);
    do_eval(1'b0, 9'h000, 9'h000, 21'd0, 1'b0);
    chk("size_cmd", 32'(ds0), 32'd3);
    do_eval(1'b0, 9'h000, 9'h006, 21'd0, 1'b0);
    chk("size_addr", 32'(ds0), 32'd8);
    do_eval(1'b0, 9'h000, 9'h0a2, 21'd0, 1'b0);
    chk("size_data", 32'(ds0), 32'd8);
    do_eval(1'b0, 9'h000, 9'h000, ex(9'h0d9, 1'b1, 9'h000, 1'b0, 1'b1), 1'b0);
    @(negedge clk);
    chk("done_one_cycle", 32'(done0), 32'd0);
    chk("idle_clears_select", 32'(msel0), 32'd0);

    // Miss: pass-through
    wr_rule(2'd0, 8'ha2, 8'hd9, 1'b0, 1'b0);
    txn(1'b0, 1'b1, 9'h006, 9'h0a2, 9'h05a, 9'h000, ex(9'h05a, 1'b0, 9'h000, 1'b0, 1'b1));

    // Priority: rules 1 and 3 both match, lowest index wins
    wr_rule(2'd1, 8'h10, 8'h11, 1'b1, 1'b0);
    wr_rule(2'd3, 8'h10, 8'h33, 1'b1, 1'b0);
    txn(1'b0, 1'b1, 9'h006, 9'h010, 9'h000, 9'h000, ex(9'h011, 1'b1, 9'h000, 1'b0, 1'b1));
    wr_rule(2'd1, 8'h10, 8'h11, 1'b0, 1'b0);
    txn(1'b0, 1'b1, 9'h006, 9'h010, 9'h000, 9'h000, ex(9'h033, 1'b1, 9'h000, 1'b0, 1'b1));

    // Write substitution requires ro=1
    wr_rule(2'd2, 8'h40, 8'h77, 1'b1, 1'b1);
    txn(1'b0, 1'b1, 9'h005, 9'h040, 9'h1ff, 9'h000, ex(9'h1ff, 1'b0, 9'h077, 1'b1, 1'b1));
    wr_rule(2'd2, 8'h40, 8'h77, 1'b1, 1'b0);
    txn(1'b0, 1'b1, 9'h005, 9'h040, 9'h000, 9'h123, ex(9'h000, 1'b0, 9'h123, 1'b0, 1'b1));
    txn(1'b0, 1'b1, 9'h006, 9'h040, 9'h000, 9'h0ab, ex(9'h077, 1'b1, 9'h0ab, 1'b0, 1'b1));

    // eval held through BUSY is ignored, then reset while in ADDR
    start(1'b0);
    do_eval(1'b0, 9'h000, 9'h000, 21'd0, 1'b1);
    chk("busy_eval_ignored", 32'(ds0), 32'd3);
    do_eval(1'b0, 9'h000, 9'h006, 21'd0, 1'b0);
    chk("in_addr_before_rst", 32'(ds0), 32'd8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_eval_done", 32'(ed0), 32'd1);
    chk("rst_mid_size", 32'(ds0), 32'd0);
    @(negedge clk);
    txn(1'b0, 1'b1, 9'h006, 9'h010, 9'h0aa, 9'h000, ex(9'h0aa, 1'b0, 9'h000, 1'b0, 1'b1));

    // Continuous instance: two reads back to back, no mitm_done
    wr_rule(2'd0, 8'ha2, 8'hd9, 1'b1, 1'b0);
    txn(1'b1, 1'b1, 9'h006, 9'h0a2, 9'h000, 9'h000, ex(9'h0d9, 1'b1, 9'h000, 1'b0, 1'b0));
    chk("cont_back_to_cmd", 32'(ds1), 32'd3);
    txn(1'b1, 1'b0, 9'h006, 9'h0a2, 9'h000, 9'h000, ex(9'h0d9, 1'b1, 9'h000, 1'b0, 1'b0));
`ifdef MITM_HIT_CNT_EN
    chk("cont_hit_count", 32'(hc1), 32'd2);
`endif
    chk("cont_no_done", 32'(done1_seen), 32'd0);

    repeat (4) @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mitm_rule_engine.md
MITM_RULE_ENGINE -- requirements
Module: mitm_rule_engine

Interface
REQ-001 SHALL have parameter MAX_DATA_SIZE, default 9, width of the data buses.
REQ-002 SHALL have parameter CMD_BITS, default 3, command word length.
REQ-003 SHALL have parameters ADDR_BITS and DATA_BITS, default 8 each, address and data word lengths, each <= MAX_DATA_SIZE.
REQ-004 SHALL have parameter NUM_RULES, default 4, number of substitution rules; RULE_IDX_W = max(1, clog2(NUM_RULES)).
REQ-005 SHALL have parameter CONTINUOUS, default 0; 1 means loop back to the command phase instead of finishing.
REQ-006 Ports: sys_clk in 1, system clock; rst in 1, reset, synchronous and active-high.
REQ-007 Ports: mitm_start in 1, start pulse; eval in 1, evaluate-word pulse.
REQ-008 Ports: real_miso_data and real_mosi_data, in, MAX_DATA_SIZE each, captured bus words, LSB-aligned.
REQ-009 Ports: rule_wr_en in 1; rule_idx in RULE_IDX_W; rule_addr in ADDR_BITS; rule_data in DATA_BITS; rule_en in 1 (rule valid); rule_ro in 1 (write-protect).
REQ-010 Ports: fake_miso_data and fake_mosi_data, out, MAX_DATA_SIZE each, substitute words.
REQ-011 Ports: data_size out clog2(MAX_DATA_SIZE+1), bit length of the next expected word.
REQ-012 Ports: fake_miso_select and fake_mosi_select, out 1 each, substitution active; eval_done out 1, ready or result valid; mitm_done out 1, one-cycle finish pulse.

Function
REQ-013 FSM states SHALL be IDLE, SYNC, CMD, ADDR, DATA and FINISH; BUSY is a 2-cycle sub-state after each accepted eval.
REQ-014 IDLE: data_size=0 and eval_done=1; mitm_start enters SYNC.
REQ-015 Each state SHALL drive data_size as SYNC 0, CMD CMD_BITS, ADDR ADDR_BITS, DATA DATA_BITS.
REQ-016 eval SHALL be accepted only when eval_done=1 outside IDLE; eval_done falls on the next edge, stays low exactly 2 cycles, and rises with results registered.
REQ-017 eval or mitm_start arriving while eval_done=0 or in the wrong state SHALL be ignored with no queuing.
REQ-018 SYNC eval SHALL ignore data and go to CMD; CMD eval SHALL latch real_mosi_data[CMD_BITS-1:0] as opcode and go to ADDR.
REQ-019 ADDR eval SHALL latch real_mosi_data[ADDR_BITS-1:0] and perform the rule lookup: the lowest-index enabled rule with an equal address wins.
REQ-020 DATA eval, opcode READ (3'b110) with hit: fake_miso_data = zero-extended rule_data, fake_miso_select=1.
REQ-021 DATA eval, opcode WRITE (3'b101) with a hit whose ro=1: fake_mosi_data = zero-extended rule_data, fake_mosi_select=1.
REQ-022 All other cases SHALL pass through: fake_x_data = real_x_data and select=0.
REQ-023 Selects and fake data SHALL hold from the DATA result until the next accepted eval or until IDLE.
REQ-024 After the DATA result, CONTINUOUS=0 SHALL go to FINISH, pulse mitm_done for one cycle, then enter IDLE.
REQ-025 After the DATA result, CONTINUOUS=1 SHALL return to CMD with no mitm_done.
REQ-026 A rule write SHALL take effect on the next edge; a lookup in the same cycle uses the old contents.
REQ-027 rule_idx >= NUM_RULES SHALL be ignored.

Reset
REQ-028 rst SHALL force IDLE, including mid-transaction, with: fake data 0, selects 0, data_size 0, eval_done 1, mitm_done 0, opcode/address 0, all rules disabled, hit count 0.

Configuration
REQ-029 With MITM_HIT_CNT_EN defined, output hit_count (16 bits) SHALL increment on each substitution, saturate at 16'hFFFF, and clear on rst.
REQ-030 Without MITM_HIT_CNT_EN, the port and the counter SHALL be absent.

Structure
REQ-031 Package mitm_pkg SHALL hold the state enum, the OP_READ and OP_WRITE constants, and the clog2 width helpers.
REQ-032 Rule storage and the priority match SHALL sit in sub-module mitm_rule_table (write port, address in, hit/idx/data/ro out, registered).

Verification
REQ-033 Reset, start, SYNC eval; CMD 110, ADDR a2 with rule0={a2,d9,en}; DATA miso 00 -> fake_miso_data=0d9, fake_miso_select=1, mitm_done pulse.
REQ-034 Same sequence with no rule matching a2, miso 5a -> fake_miso_data=05a, select=0.
REQ-035 Rules 1 and 3 both hold address 10 with data 11 and 33 -> read returns 011.
REQ-036 WRITE 101, ADDR 40, rule ro=1 data 77, mosi 00 -> fake_mosi_data=077, fake_mosi_select=1; same case with ro=0 -> pass-through.
REQ-037 eval during BUSY is ignored; rst asserted in ADDR -> IDLE next cycle, eval_done=1, later lookups miss.
REQ-038 CONTINUOUS=1, two back-to-back reads with no mitm_done; with MITM_HIT_CNT_EN, hit_count=2.
